wb_sequencer: RTL and testbench



---
 rtl/wb_pkg.sv | 69 ++++++
 rtl/wb_sequencer_if.sv | 30 +++
 rtl/wb_dest_decode.sv | 25 ++
 rtl/wb_sequencer.sv | 133 +++++++++++++
 tb/tb_wb_sequencer.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/wb_pkg.sv
// Shared encodings for the register-file writeback sequencer and the hazard unit.
// Holds class/select/source encodings, the FSM state enum and the first-write decode helper.
package wb_pkg;

  localparam logic [4:0] REG_SP = 5'd29;
  localparam logic [4:0] REG_RA = 5'd31;

  typedef enum logic [2:0] {
    WB_NONE   = 3'd0,
    WB_RTYPE  = 3'd1,
    WB_ITYPE  = 3'd2,
    WB_LINK   = 3'd3,
    WB_PUSH   = 3'd4,
    WB_POP    = 3'd5,
    WB_RSDEST = 3'd6,
    WB_RSVD   = 3'd7
  } wb_class_t;

  typedef enum logic [2:0] {
    DST_RT = 3'd0,
    DST_RD = 3'd1,
    DST_SP = 3'd2,
    DST_RA = 3'd3,
    DST_RS = 3'd4
  } regdst_t;

  typedef enum logic [1:0] {
    SRC_ALU   = 2'd0,
    SRC_MEM   = 2'd1,
    SRC_PC4   = 2'd2,
    SRC_SPADJ = 2'd3
  } wb_src_t;

  typedef enum logic [1:0] {
    SP_NONE = 2'd0,
    SP_DEC  = 2'd1,
    SP_INC  = 2'd2
  } sp_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR1  = 2'd1,
    ST_WR2  = 2'd2,
    ST_FIN  = 2'd3
  } state_t;

  typedef struct packed {
    regdst_t sel;
    wb_src_t src;
    sp_op_t  sp;
  } wr_ctl_t;

  // Controls for the first (often only) write of a class; POP's second write is fixed.
  function automatic wr_ctl_t first_write(input wb_class_t cls);
    wr_ctl_t c;
    c = '{sel: DST_RT, src: SRC_ALU, sp: SP_NONE};
    case (cls)
      WB_RTYPE:  c = '{sel: DST_RD, src: SRC_ALU,   sp: SP_NONE};
      WB_ITYPE:  c = '{sel: DST_RT, src: SRC_ALU,   sp: SP_NONE};
      WB_LINK:   c = '{sel: DST_RA, src: SRC_PC4,   sp: SP_NONE};
      WB_PUSH:   c = '{sel: DST_SP, src: SRC_SPADJ, sp: SP_DEC};
      WB_POP:    c = '{sel: DST_RT, src: SRC_MEM,   sp: SP_NONE};
      WB_RSDEST: c = '{sel: DST_RS, src: SRC_ALU,   sp: SP_NONE};
      default:   c = '{sel: DST_RT, src: SRC_ALU,   sp: SP_NONE};
    endcase
    return c;
  endfunction

endpackage

// File: rtl/wb_sequencer_if.sv
// Writeback request/control bundle between the control FSM (master) and the sequencer (slave).
// COUNT_W sizes the writeback-event counter carried back to the master.
interface wb_sequencer_if #(parameter int COUNT_W = 8);

  logic               req;
  logic [2:0]         wb_class;
  logic [4:0]         rs;
  logic [4:0]         rt;
  logic [4:0]         rd;
  logic               hold;
  logic               ready;
  logic               done;
  logic [2:0]         RegDst;
  logic               RegWrite;
  logic [1:0]         wb_src;
  logic [1:0]         sp_op;
  logic [4:0]         dest_idx;
  logic [COUNT_W-1:0] wb_count;

  modport master (
    output req, wb_class, rs, rt, rd, hold,
    input  ready, done, RegDst, RegWrite, wb_src, sp_op, dest_idx, wb_count
  );

  modport slave (
    input  req, wb_class, rs, rt, rd, hold,
    output ready, done, RegDst, RegWrite, wb_src, sp_op, dest_idx, wb_count
  );

endinterface

// File: rtl/wb_dest_decode.sv
// Resolves the RegDst select plus instruction fields into a register number.
// Purely combinational; shared with the hazard unit.
module wb_dest_decode
  import wb_pkg::*;
(
  input  regdst_t    sel,
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  input  logic [4:0] rd,
  output logic [4:0] dest_idx
);

  always_comb begin
    dest_idx = 5'd0;
    case (sel)
      DST_RT:  dest_idx = rt;
      DST_RD:  dest_idx = rd;
      DST_SP:  dest_idx = REG_SP;
      DST_RA:  dest_idx = REG_RA;
      DST_RS:  dest_idx = rs;
      default: dest_idx = 5'd0;
    endcase
  end

endmodule

// File: rtl/wb_sequencer.sv
// Multicycle writeback sequencer: one request becomes one or two register-file writes (POP: rt then $29).
// Optional WB_ZERO_GUARD_EN suppresses writes whose resolved destination is $0.
module wb_sequencer
  import wb_pkg::*;
#(
  parameter int COUNT_W = 8
) (
  input logic            clk,
  input logic            reset,
  wb_sequencer_if.slave  bus
);

  state_t             state_q;
  wb_class_t          cls_q;
  logic [4:0]         rs_q;
  logic [4:0]         rt_q;
  logic [4:0]         rd_q;
  regdst_t            sel_q;
  wb_src_t            src_q;
  sp_op_t             sp_q;
  logic               ready_q;
  logic               done_q;
  logic [COUNT_W-1:0] count_q;

  logic [4:0] dest_raw;
  logic [4:0] dest_idx;
  logic       writing;
  logic       suppress;
  logic       reg_write;
  wr_ctl_t    wr1;

  wb_dest_decode u_dest_decode (
    .sel      (sel_q),
    .rs       (rs_q),
    .rt       (rt_q),
    .rd       (rd_q),
    .dest_idx (dest_raw)
  );

  assign writing  = (state_q == ST_WR1) || (state_q == ST_WR2);
  assign dest_idx = writing ? dest_raw : 5'd0;

`ifdef WB_ZERO_GUARD_EN
  assign suppress = bus.hold || (dest_idx == 5'd0);
`else
  assign suppress = bus.hold;
`endif

  // Strobe is held off while stalled; the state itself only waits on hold, never on the guard.
  assign reg_write = writing && !suppress;
  assign wr1       = first_write(wb_class_t'(bus.wb_class));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cls_q   <= WB_NONE;
      rs_q    <= 5'd0;
      rt_q    <= 5'd0;
      rd_q    <= 5'd0;
      sel_q   <= DST_RT;
      src_q   <= SRC_ALU;
      sp_q    <= SP_NONE;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      count_q <= '0;
    end else begin
      if (reg_write) begin
        count_q <= count_q + COUNT_W'(1);
      end
      case (state_q)
        ST_IDLE: begin
          if (bus.req) begin
            cls_q   <= wb_class_t'(bus.wb_class);
            rs_q    <= bus.rs;
            rt_q    <= bus.rt;
            rd_q    <= bus.rd;
            ready_q <= 1'b0;
            if (bus.wb_class == WB_NONE || bus.wb_class == WB_RSVD) begin
              state_q <= ST_FIN;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_WR1;
              sel_q   <= wr1.sel;
              src_q   <= wr1.src;
              sp_q    <= wr1.sp;
            end
          end
        end
        ST_WR1: begin
          if (!bus.hold) begin
            if (cls_q == WB_POP) begin
              state_q <= ST_WR2;
              sel_q   <= DST_SP;
              src_q   <= SRC_SPADJ;
              sp_q    <= SP_INC;
            end else begin
              state_q <= ST_FIN;
              sel_q   <= DST_RT;
              src_q   <= SRC_ALU;
              sp_q    <= SP_NONE;
              done_q  <= 1'b1;
            end
          end
        end
        ST_WR2: begin
          if (!bus.hold) begin
            state_q <= ST_FIN;
            sel_q   <= DST_RT;
            src_q   <= SRC_ALU;
            sp_q    <= SP_NONE;
            done_q  <= 1'b1;
          end
        end
        ST_FIN: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
          ready_q <= 1'b1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.ready    = ready_q;
  assign bus.done     = done_q;
  assign bus.RegDst   = sel_q;
  assign bus.RegWrite = reg_write;
  assign bus.wb_src   = src_q;
  assign bus.sp_op    = reg_write ? sp_q : SP_NONE;
  assign bus.dest_idx = dest_idx;
  assign bus.wb_count = count_q;

endmodule

// File: tb/tb_wb_sequencer.sv
// Bench for wb_sequencer: directed scenarios then random requests against a per-class write-list model.
// Two instances (COUNT_W 8 and 2) share stimulus so counter wrap is observed on the narrow one.
module tb_wb_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       req;
  logic [2:0] wb_class;
  logic [4:0] rs, rt, rd;
  logic       hold;

  int checks = 0;
  int errors = 0;
  int total_writes = 0;
  bit guard;

  always #5 clk = ~clk;

  wb_sequencer_if #(.COUNT_W(8)) if8 ();
  wb_sequencer_if #(.COUNT_W(2)) if2 ();

  assign if8.req = req;   assign if2.req = req;
  assign if8.wb_class = wb_class; assign if2.wb_class = wb_class;
  assign if8.rs = rs;     assign if2.rs = rs;
  assign if8.rt = rt;     assign if2.rt = rt;
  assign if8.rd = rd;     assign if2.rd = rd;
  assign if8.hold = hold; assign if2.hold = hold;

  wb_sequencer #(.COUNT_W(8)) dut8 (.clk(clk), .reset(reset), .bus(if8.slave));
  wb_sequencer #(.COUNT_W(2)) dut2 (.clk(clk), .reset(reset), .bus(if2.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Model: the list of register writes a class performs, straight from the class table.
  function automatic int num_writes(input int c);
    case (c)
      1, 2, 3, 4, 6: return 1;
      5:             return 2;
      default:       return 0;
    endcase
  endfunction

  task automatic exp_write(input int c, input int k, input logic [4:0] frs, input logic [4:0] frt,
                           input logic [4:0] frd, output int sel, output int dst,
                           output int src, output int sp);
    sel = 0; dst = 0; src = 0; sp = 0;
    case (c)
      1: begin sel = 1; dst = frd; end
      2: begin sel = 0; dst = frt; end
      3: begin sel = 3; dst = 31; src = 2; end
      4: begin sel = 2; dst = 29; src = 3; sp = 1; end
      5: if (k == 0) begin sel = 0; dst = frt; src = 1; end
         else        begin sel = 2; dst = 29; src = 3; sp = 2; end
      6: begin sel = 4; dst = frs; end
      default: ;
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble(input bit noise);
    req = noise;
    wb_class = 3'($urandom);
    rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom);
  endtask

  task automatic chk_counts(input string tag);
    chk({tag, "_cnt8"}, 32'(if8.wb_count), total_writes % 256);
    chk({tag, "_cnt2"}, 32'(if2.wb_count), total_writes % 4);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_rw"},    32'(if8.RegWrite), 0);
    chk({tag, "_sel"},   32'(if8.RegDst), 0);
    chk({tag, "_src"},   32'(if8.wb_src), 0);
    chk({tag, "_sp"},    32'(if8.sp_op), 0);
    chk({tag, "_dest"},  32'(if8.dest_idx), 0);
  endtask

  // Called at the drive point of an IDLE cycle; returns at the drive point of the next IDLE cycle.
  task automatic run_txn(input int c, input logic [4:0] frs, input logic [4:0] frt,
                         input logic [4:0] frd, input int h0, input int h1, input bit noise);
    int sel, dst, src, sp, hc, rw;
    req = 1'b1; wb_class = 3'(c); rs = frs; rt = frt; rd = frd; hold = 1'($urandom);
    #1;
    chk("idle_ready", 32'(if8.ready), 1);
    chk("idle_done", 32'(if8.done), 0);
    chk_quiet("idle");
    tick();
    for (int k = 0; k < num_writes(c); k++) begin
      exp_write(c, k, frs, frt, frd, sel, dst, src, sp);
      hc = (k == 0) ? h0 : h1;
      for (int j = 0; j < hc; j++) begin
        scramble(noise); hold = 1'b1;
        #1;
        chk("hold_rw", 32'(if8.RegWrite), 0);
        chk("hold_sp", 32'(if8.sp_op), 0);
        chk("hold_sel", 32'(if8.RegDst), sel);
        chk("hold_dest", 32'(if8.dest_idx), dst);
        chk("hold_src", 32'(if8.wb_src), src);
        chk("hold_busy", 32'({if8.ready, if8.done}), 0);
        tick();
      end
      scramble(noise); hold = 1'b0;
      rw = (guard && dst == 0) ? 0 : 1;
      #1;
      chk("wr_rw", 32'(if8.RegWrite), rw);
      chk("wr_sp", 32'(if8.sp_op), rw ? sp : 0);
      chk("wr_sel", 32'(if8.RegDst), sel);
      chk("wr_dest", 32'(if8.dest_idx), dst);
      chk("wr_src", 32'(if8.wb_src), src);
      chk("wr_busy", 32'({if8.ready, if8.done}), 0);
      total_writes += rw;
      tick();
    end
    scramble(noise); hold = 1'($urandom);
    #1;
    chk("fin_done", 32'(if8.done), 1);
    chk("fin_ready", 32'(if8.ready), 0);
    chk_quiet("fin");
    tick();
    req = 1'b0; hold = 1'b0;
    #1;
    chk("post_ready", 32'(if8.ready), 1);
    chk("post_done", 32'(if8.done), 0);
    chk_counts("post");
  endtask

  initial begin
`ifdef WB_ZERO_GUARD_EN
    guard = 1'b1;
`else
    guard = 1'b0;
`endif
    reset = 1'b1; req = 1'b0; wb_class = 3'd0; rs = 5'd0; rt = 5'd0; rd = 5'd0; hold = 1'b0;
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("rst_ready", 32'(if8.ready), 1);
    chk("rst_done", 32'(if8.done), 0);
    chk_quiet("rst");
    chk_counts("rst");

    // Directed scenarios
    run_txn(1, 5'd3, 5'd4, 5'd9, 0, 0, 1'b0);   // RTYPE rd=9
    run_txn(5, 5'd1, 5'd8, 5'd2, 0, 0, 1'b0);   // POP rt=8
    run_txn(3, 5'd1, 5'd2, 5'd3, 3, 0, 1'b1);   // LINK, 3 held cycles, busy req noise
    run_txn(2, 5'd5, 5'd0, 5'd6, 0, 0, 1'b0);   // ITYPE rt=0
    run_txn(7, 5'd5, 5'd6, 5'd7, 0, 0, 1'b1);   // reserved class
    run_txn(0, 5'd5, 5'd6, 5'd7, 0, 0, 1'b0);   // NONE
    run_txn(5, 5'd1, 5'd8, 5'd2, 2, 2, 1'b1);   // POP with holds on both writes

    // Reset during WR1 of PUSH: no done, everything back to reset values
    #1; req = 1'b1; wb_class = 3'd4; #1;
    tick();
    req = 1'b0; #1;
    chk("push_wr1_rw", 32'(if8.RegWrite), 1);
    chk("push_wr1_dest", 32'(if8.dest_idx), 29);
    reset = 1'b1;
    tick();
    reset = 1'b0; total_writes = 0; #1;
    chk("midrst_ready", 32'(if8.ready), 1);
    chk("midrst_done", 32'(if8.done), 0);
    chk_quiet("midrst");
    chk_counts("midrst");
    tick(); #1;
    chk("midrst_nodone", 32'(if8.done), 0);
    chk("midrst_idle", 32'(if8.ready), 1);

    // Simultaneous reset and req: the request is dropped
    reset = 1'b1; req = 1'b1; wb_class = 3'd1; rd = 5'd9;
    tick();
    reset = 1'b0; req = 1'b0; #1;
    chk("rstreq_ready", 32'(if8.ready), 1);
    tick(); #1;
    chk("rstreq_still_idle", 32'(if8.ready), 1);
    chk("rstreq_rw", 32'(if8.RegWrite), 0);
    chk("rstreq_done", 32'(if8.done), 0);

    // Narrow counter wrap: five RTYPE writes -> 1,2,3,0,1
    for (int i = 0; i < 5; i++) begin
      run_txn(1, 5'd0, 5'd0, 5'(i + 1), 0, 0, 1'b0);
      chk("wrap_seq", 32'(if2.wb_count), (i + 1) % 4);
    end

    // Random requests
    for (int i = 0; i < 60; i++) begin
      run_txn($urandom_range(0, 7), 5'($urandom), 5'($urandom), 5'($urandom),
              $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
